// File: rtl/fifo_read_upsizer_pkg.sv
// Shared sizing helpers for the FIFO read upsizer.
// Optional flush feature: FIFO_READ_UPSIZER_FLUSH_EN (see fifo_read_upsizer.sv).
package fifo_read_upsizer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_RATIO = 4;

  // Width of the fill counter: holds 0..ratio-1.
  function automatic int unsigned cnt_w(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  // Width of the out_count field: holds 0..ratio.
  function automatic int unsigned count_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  // out_count type for the default ratio.
  typedef logic [$clog2(DEFAULT_RATIO + 1)-1:0] out_count_t;

endpackage

// File: rtl/fifo_read_upsizer_wide_out_reg.sv
// Valid/ready holding register for the wide output word.
// A load always wins; otherwise an accepted word drops valid, a stalled word holds.
module wide_out_reg #(
  parameter int unsigned data_w = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [data_w-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [data_w-1:0] out_data,
  output logic              stall
);

  // Word is offered but the sink refuses it this cycle.
  always_comb begin
    stall = out_valid & ~out_ready;
  end

  // Output register: load new word, drain on acceptance, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {data_w{1'b0}};
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/fifo_read_upsizer.sv
// Pops narrow words from a show-ahead FIFO and packs `ratio` of them into one
// wide word (first popped word in the lowest lane), offered on valid/ready.
// Optional macro FIFO_READ_UPSIZER_FLUSH_EN adds a flush input that emits a
// zero-padded partial word, plus an out_count output.
module fifo_read_upsizer
  import fifo_read_upsizer_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH,
  parameter int unsigned ratio = DEFAULT_RATIO
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
  input  logic                      flush,
  output logic [count_w(ratio)-1:0] out_count,
`endif
  input  logic                      fifo_empty,
  input  logic [width-1:0]          fifo_read_data,
  output logic                      fifo_pop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [width*ratio-1:0]    out_data
);

  localparam int unsigned CW   = cnt_w(ratio);
  localparam int unsigned WIDE = width * ratio;
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
  localparam int unsigned KW    = count_w(ratio);
  localparam int unsigned REG_W = WIDE + KW;
`else
  localparam int unsigned REG_W = WIDE;
`endif

  logic [CW-1:0]    cnt_r;
  logic [width-1:0] buf_r [ratio-1];
  logic             full_s;
  logic             stall_s;
  logic             pop_s;
  logic             load_s;
  logic             flush_hold_s;
  logic             do_flush_s;
  logic [WIDE-1:0]  word_s;
  logic [REG_W-1:0] load_bus_s;
  logic [REG_W-1:0] out_bus_s;

  // Assembly buffer is one pop away from a complete word.
  always_comb begin
    full_s = (cnt_r == CW'(ratio - 1));
  end

`ifdef FIFO_READ_UPSIZER_FLUSH_EN
  logic           flush_pend_r;
  logic           flush_req_s;
  logic [KW-1:0]  count_s;

  // A flush with a non-empty partial blocks pops; it fires once no stall.
  always_comb begin
    flush_req_s  = flush | flush_pend_r;
    flush_hold_s = flush_req_s & (cnt_r != {CW{1'b0}});
    do_flush_s   = flush_hold_s & ~stall_s;
    count_s      = do_flush_s ? KW'(cnt_r) : KW'(ratio);
  end

  // Remember a flush that arrived while the output was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_r <= 1'b0;
    end else begin
      flush_pend_r <= flush_hold_s & stall_s;
    end
  end
`else
  // Without the flush feature no partial word is ever emitted.
  always_comb begin
    flush_hold_s = 1'b0;
    do_flush_s   = 1'b0;
  end
`endif

  // Pop whenever data is there, except when completing would overwrite a stalled word.
  always_comb begin
    pop_s  = rst_n & ~fifo_empty & ~(full_s & stall_s) & ~flush_hold_s;
    load_s = (pop_s & full_s) | do_flush_s;
  end

  assign fifo_pop = pop_s;

  // Build the wide word: buffered lanes plus the head word, or a padded partial on flush.
  always_comb begin
    word_s = {WIDE{1'b0}};
    for (int i = 0; i < int'(ratio) - 1; i++) begin
      if (!do_flush_s || (i < int'(cnt_r))) begin
        word_s[i*width +: width] = buf_r[i];
      end else begin
        word_s[i*width +: width] = {width{1'b0}};
      end
    end
    if (!do_flush_s) begin
      word_s[WIDE-1 -: width] = fifo_read_data;
    end else begin
      word_s[WIDE-1 -: width] = {width{1'b0}};
    end
  end

`ifdef FIFO_READ_UPSIZER_FLUSH_EN
  // Carry the lane count alongside the data through the output register.
  always_comb begin
    load_bus_s = {count_s, word_s};
    out_count  = out_bus_s[REG_W-1 -: KW];
    out_data   = out_bus_s[WIDE-1:0];
  end
`else
  // Output register carries the data only.
  always_comb begin
    load_bus_s = word_s;
    out_data   = out_bus_s;
  end
`endif

  // Fill counter and assembly buffer; a completing pop or flush restarts the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      for (int i = 0; i < int'(ratio) - 1; i++) begin
        buf_r[i] <= {width{1'b0}};
      end
    end else if (do_flush_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (pop_s) begin
      if (full_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        buf_r[cnt_r] <= fifo_read_data;
        cnt_r        <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  wide_out_reg #(
    .data_w(REG_W)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_data(load_bus_s),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_bus_s),
    .stall    (stall_s)
  );

endmodule

// File: tb/tb_fifo_read_upsizer.sv
// Self-checking bench for fifo_read_upsizer (width=8, ratio=4).
// The FIFO is a show-ahead queue; a word-level model predicts pops and output words.
// Define FIFO_READ_UPSIZER_FLUSH_EN to also exercise the flush feature.
module tb_fifo_read_upsizer;
  import fifo_read_upsizer_pkg::*;

  localparam int W = 8;
  localparam int R = 4;

  logic           clk;
  logic           rst_n;
  logic           fifo_empty;
  logic [W-1:0]   fifo_read_data;
  logic           fifo_pop;
  logic           out_valid;
  logic           out_ready;
  logic [W*R-1:0] out_data;
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
  logic           flush;
  out_count_t     out_count;
`endif

  fifo_read_upsizer #(.width(W), .ratio(R)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
    .flush         (flush),
    .out_count     (out_count),
`endif
    .fifo_empty    (fifo_empty),
    .fifo_read_data(fifo_read_data),
    .fifo_pop      (fifo_pop),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench FIFO contents and model state.
  logic [W-1:0]   fq[$];
  logic [W-1:0]   held[$];
  bit             mvalid;
  logic [W*R-1:0] mdata;
  int             mcount;
  bit             mpend;
  bit             hole;
  bit             flush_v;
  int             checks;
  int             errors;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W*R-1:0] pack(input int n);
    logic [W*R-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*W +: W] = held[i];
    return r;
  endfunction

  task automatic drive_inputs();
    fifo_empty     = hole || (fq.size() == 0);
    fifo_read_data = (fq.size() > 0) ? fq[0] : 8'h00;
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
    flush = flush_v;
`endif
  endtask

  // One clock: drive at negedge, compare, advance the model, let the DUT take the edge.
  task automatic cycle(input bit rdy, input bit h, input bit fl);
    bit stall;
    bit exp_pop;
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
    bit freq;
`endif
    @(negedge clk);
    out_ready = rdy;
    hole      = h;
    flush_v   = fl;
    drive_inputs();
    #1;
    stall   = mvalid && !rdy;
    exp_pop = !fifo_empty && !((held.size() == R - 1) && stall);
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
    freq = fl || mpend;
    if (freq && held.size() > 0) exp_pop = 1'b0;
`endif
    check("fifo_pop", fifo_pop, exp_pop);
    check("out_valid", out_valid, mvalid);
    if (mvalid) begin
      check("out_data", out_data, mdata);
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
      check("out_count", out_count, mcount);
`endif
    end
    if (mvalid && rdy) mvalid = 1'b0;
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
    if (freq && held.size() > 0) begin
      if (!stall) begin
        mdata  = pack(held.size());
        mcount = held.size();
        mvalid = 1'b1;
        held.delete();
        mpend  = 1'b0;
      end else begin
        mpend = 1'b1;
      end
    end else begin
      mpend = 1'b0;
    end
`endif
    if (exp_pop) begin
      held.push_back(fq.pop_front());
      if (held.size() == R) begin
        mdata  = pack(R);
        mcount = R;
        mvalid = 1'b1;
        held.delete();
      end
    end
    @(posedge clk);
  endtask

  // Assert reset at a negedge, check reset outputs, release just after a posedge.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    hole      = 1'b0;
    flush_v   = 1'b0;
    out_ready = 1'b1;
    drive_inputs();
    held.delete();
    mvalid = 1'b0;
    mdata  = '0;
    mcount = 0;
    mpend  = 1'b0;
    #1;
    check("pop_in_reset", fifo_pop, 1'b0);
    check("valid_in_reset", out_valid, 1'b0);
    check("data_in_reset", out_data, 32'h0);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    hole    = 1'b0;
    flush_v = 1'b0;
    out_ready = 1'b1;
    drive_inputs();

    // Reset with four words waiting, then one wide word.
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset(2);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    #1;
    check("first_valid", out_valid, 1'b1);
    check("first_word", out_data, 32'h44332211);
    cycle(1'b1, 1'b0, 1'b0);

    // Streaming eight words with ready high.
    fq = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc};
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    #1;
    check("stream_second", out_data, 32'hccbbaa99);
    check("stream_valid", out_valid, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);

    // Sink stalled with eight words queued.
    fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    #1;
    check("stall_hold", out_data, 32'h04030201);
    check("stall_pop", fifo_pop, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);

    // FIFO empty every other cycle.
    fq = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7};
    for (int i = 0; i < 16; i++) cycle(1'b1, (i % 2) == 0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // Reset with a partial word held, then four fresh words.
    fq = '{8'hde, 8'had};
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    do_reset(2);
    fq = '{8'h10, 8'h20, 8'h30, 8'h40};
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    #1;
    check("after_reset_word", out_data, 32'h40302010);
    cycle(1'b1, 1'b0, 1'b0);

`ifdef FIFO_READ_UPSIZER_FLUSH_EN
    // Two words then flush.
    fq = '{8'h11, 8'h22};
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    #1;
    check("flush_word", out_data, 32'h00002211);
    check("flush_count", out_count, 2);
    cycle(1'b1, 1'b0, 1'b0);
`endif

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 1) == 1 && fq.size() < 16) fq.push_back(8'($urandom));
`ifdef FIFO_READ_UPSIZER_FLUSH_EN
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
`else
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b0);
`endif
    end
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    check("fifo_drained", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
